// File: rtl/coin_acceptor_if.sv
// Signal bundle between the coin acceptor and its surroundings: raw slot sensors and
// downstream busy in, coin code and reject gate out; audit counters only with COIN_AUDIT_EN.
interface coin_acceptor_if;
    logic       sense5_raw;
    logic       sense10_raw;
    logic       busy;
    logic [1:0] coin;
    logic       reject;
`ifdef COIN_AUDIT_EN
    logic [7:0] accepted_cnt;
    logic [7:0] rejected_cnt;

    modport master (
        output sense5_raw, sense10_raw, busy,
        input  coin, reject, accepted_cnt, rejected_cnt
    );
    modport slave (
        input  sense5_raw, sense10_raw, busy,
        output coin, reject, accepted_cnt, rejected_cnt
    );
`else
    modport master (
        output sense5_raw, sense10_raw, busy,
        input  coin, reject
    );
    modport slave (
        input  sense5_raw, sense10_raw, busy,
        output coin, reject
    );
`endif
endinterface

// File: rtl/coin_acceptor.sv
// Coin acceptor: synchronizes and debounces the 5/10 Rs slot sensors, classifies coins and
// hands them to a vending controller through a one-entry pending slot. Optional audit counters: COIN_AUDIT_EN.
module coin_acceptor #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic            clk,
    input  logic            reset,
    coin_acceptor_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE,
        DEBOUNCE,
        WAIT_RELEASE
    } state_t;

    localparam logic [3:0] CNT_FULL = 4'(DEBOUNCE_CYCLES);
    localparam logic [3:0] CNT_LAST = 4'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] PAT_NONE = 2'b00;
    localparam logic [1:0] PAT_5    = 2'b01;
    localparam logic [1:0] PAT_10   = 2'b10;
    localparam logic [1:0] PAT_BAD  = 2'b11;

    logic [1:0] meta_q, sync_q;
    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [1:0] pat_q, pat_d;
    logic [1:0] pend_q, pend_d;
    logic [1:0] coin_q, coin_d;
    logic       reject_q, reject_d;
    logic       classify;
    logic       valid_cls;
    logic       bad_cls;
    logic       can_emit;

    // Sensor levels are asynchronous to clk; bit 1 carries the 10 Rs slot, bit 0 the 5 Rs slot.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= PAT_NONE;
            sync_q <= PAT_NONE;
        end else begin
            meta_q <= {bus.sense10_raw, bus.sense5_raw};
            sync_q <= meta_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= WAIT_RELEASE;
            cnt_q    <= '0;
            pat_q    <= PAT_NONE;
            pend_q   <= PAT_NONE;
            coin_q   <= PAT_NONE;
            reject_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pat_q    <= pat_d;
            pend_q   <= pend_d;
            coin_q   <= coin_d;
            reject_q <= reject_d;
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pat_d    = pat_q;
        classify = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (sync_q != PAT_NONE) begin
                    state_d = DEBOUNCE;
                    pat_d   = sync_q;
                    cnt_d   = 4'd1;
                end
            end
            DEBOUNCE: begin
                if (cnt_q == CNT_FULL) begin
                    classify = 1'b1;
                    state_d  = WAIT_RELEASE;
                    cnt_d    = '0;
                end else if (sync_q == PAT_NONE) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (sync_q == pat_q) begin
                    cnt_d = cnt_q + 4'd1;
                end else begin
                    pat_d = sync_q;
                    cnt_d = 4'd1;
                end
            end
            WAIT_RELEASE: begin
                if (sync_q != PAT_NONE) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = WAIT_RELEASE;
                cnt_d   = '0;
            end
        endcase
    end

    assign valid_cls = classify && (pat_q == PAT_5 || pat_q == PAT_10);
    assign bad_cls   = classify && (pat_q == PAT_BAD);
    // Emitting only after an idle coin cycle keeps coin pulses separated.
    assign can_emit  = !bus.busy && (coin_q == PAT_NONE);

    // A reject cycle defers any pending emission so coin and reject never coincide.
    always_comb begin
        coin_d   = PAT_NONE;
        reject_d = 1'b0;
        pend_d   = pend_q;
        if (bad_cls) begin
            reject_d = 1'b1;
        end else if (valid_cls) begin
            if (pend_q == PAT_NONE) begin
                if (can_emit) coin_d = pat_q;
                else          pend_d = pat_q;
            end else if (can_emit) begin
                coin_d = pend_q;
                pend_d = pat_q;
            end else begin
                reject_d = 1'b1;
            end
        end else if (pend_q != PAT_NONE && can_emit) begin
            coin_d = pend_q;
            pend_d = PAT_NONE;
        end
    end

    assign bus.coin   = coin_q;
    assign bus.reject = reject_q;

`ifdef COIN_AUDIT_EN
    logic [7:0] acc_q, rej_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q <= '0;
            rej_q <= '0;
        end else begin
            if (coin_q != PAT_NONE && acc_q != 8'hFF) acc_q <= acc_q + 8'd1;
            if (reject_q && rej_q != 8'hFF)           rej_q <= rej_q + 8'd1;
        end
    end

    assign bus.accepted_cnt = acc_q;
    assign bus.rejected_cnt = rej_q;
`endif

endmodule

// File: tb/tb_coin_acceptor.sv
// Self-checking bench for coin_acceptor: directed scenarios plus randomized insertions
// compared every cycle against a run-length based reference model.
module tb_coin_acceptor;

    localparam int N = 4;

    logic clk;
    logic reset;
    coin_acceptor_if bus ();

    coin_acceptor #(.DEBOUNCE_CYCLES(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model: sensor samples reach the classifier two edges late; a coin is the
    // pattern repeated N times after the slot has been empty for N samples.
    bit [1:0] mp1, mp2, m_pat, m_pend, m_coin;
    bit       m_rej, m_armed;
    int       m_zeros, m_run, m_acc, m_rejc;

    task automatic model_step();
        bit [1:0] samp, cls, nc;
        bit       nr, can_emit;
        if (reset) begin
            mp1 = 0; mp2 = 0; m_pat = 0; m_pend = 0; m_coin = 0; m_rej = 0;
            m_armed = 0; m_zeros = 0; m_run = 0; m_acc = 0; m_rejc = 0;
            return;
        end
        if (m_coin != 0 && m_acc < 255) m_acc++;
        if (m_rej && m_rejc < 255) m_rejc++;
        samp = mp2;
        mp2  = mp1;
        mp1  = {bus.sense10_raw, bus.sense5_raw};
        cls  = 0;
        if (!m_armed) begin
            m_zeros = (samp == 0) ? m_zeros + 1 : 0;
            if (m_zeros == N) begin
                m_armed = 1;
                m_run   = 0;
            end
        end else if (m_run == N) begin
            cls = m_pat; m_armed = 0; m_zeros = 0; m_run = 0;
        end else if (samp == 0) begin
            m_run = 0;
        end else if (m_run > 0 && samp == m_pat) begin
            m_run++;
        end else begin
            m_pat = samp; m_run = 1;
        end
        can_emit = !bus.busy && m_coin == 0;
        nc = 0;
        nr = 0;
        if (cls == 3) begin
            nr = 1;
        end else if (cls != 0) begin
            if (m_pend == 0) begin
                if (can_emit) nc = cls;
                else          m_pend = cls;
            end else if (can_emit) begin
                nc = m_pend; m_pend = cls;
            end else begin
                nr = 1;
            end
        end else if (m_pend != 0 && can_emit) begin
            nc = m_pend; m_pend = 0;
        end
        m_coin = nc;
        m_rej  = nr;
    endtask

    int n_coin_seen, n_rej_seen, last_coin;

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check("coin", int'(bus.coin), int'(m_coin));
        check("reject", int'(bus.reject), int'(m_rej));
`ifdef COIN_AUDIT_EN
        check("accepted_cnt", int'(bus.accepted_cnt), m_acc);
        check("rejected_cnt", int'(bus.rejected_cnt), m_rejc);
`endif
        if (bus.coin != 0) begin
            n_coin_seen++;
            last_coin = int'(bus.coin);
        end
        if (bus.reject) n_rej_seen++;
    endtask

    task automatic run_ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic clear_seen();
        n_coin_seen = 0;
        n_rej_seen  = 0;
        last_coin   = 0;
    endtask

    task automatic set_sensors(input bit [1:0] pat);
        bus.sense10_raw = pat[1];
        bus.sense5_raw  = pat[0];
    endtask

    task automatic insert(input bit [1:0] pat, input int len, input int gap);
        set_sensors(pat);
        run_ticks(len);
        set_sensors(2'b00);
        run_ticks(gap);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int first;
        reset = 1'b1;
        bus.busy = 1'b0;
        set_sensors(2'b00);
        clear_seen();

        run_ticks(2);
        check("reset_coin", int'(bus.coin), 0);
        check("reset_reject", int'(bus.reject), 0);
        reset = 1'b0;
        run_ticks(N + 3);

        // Latency: coin must appear on the (N+3)th sampling cycle and last exactly one cycle.
        clear_seen();
        first = 0;
        set_sensors(2'b01);
        for (int j = 1; j <= 20; j++) begin
            tick();
            if (bus.coin != 0 && first == 0) first = j;
        end
        check("latency_tick", first, N + 3);
        check("latency_pulses", n_coin_seen, 1);
        check("latency_code", last_coin, 1);
        check("latency_reject", n_rej_seen, 0);
        set_sensors(2'b00);
        run_ticks(N + 4);

        // Short 10 Rs glitch is ignored.
        clear_seen();
        insert(2'b10, 2, 12);
        check("glitch_coin", n_coin_seen, 0);
        check("glitch_reject", n_rej_seen, 0);

        // Both sensors together: invalid coin.
        clear_seen();
        insert(2'b11, N + 4, N + 4);
        check("invalid_coin", n_coin_seen, 0);
        check("invalid_reject", n_rej_seen, 1);
`ifdef COIN_AUDIT_EN
        check("invalid_rejected_cnt", int'(bus.rejected_cnt), 1);
        check("invalid_accepted_cnt", int'(bus.accepted_cnt), 1);
`endif

        // Busy controller: first coin parks in pending, second is rejected.
        clear_seen();
        bus.busy = 1'b1;
        insert(2'b10, N + 4, N + 4);
        insert(2'b01, N + 4, N + 4);
        check("busy_coin_held", n_coin_seen, 0);
        check("busy_reject", n_rej_seen, 1);
        bus.busy = 1'b0;
        run_ticks(4);
        check("busy_release_pulses", n_coin_seen, 1);
        check("busy_release_code", last_coin, 2);

        // Reset in the middle of a debounce with the coin still present.
        clear_seen();
        set_sensors(2'b01);
        run_ticks(4);
        reset = 1'b1;
        run_ticks(1);
        reset = 1'b0;
        run_ticks(20);
        check("reset_mid_coin", n_coin_seen, 0);
        set_sensors(2'b00);
        run_ticks(N + 4);
        insert(2'b01, N + 4, N + 4);
        check("reset_fresh_coin", n_coin_seen, 1);
        check("reset_fresh_code", last_coin, 1);

        // Randomized insertions, glitches, pattern changes, busy traffic and occasional resets.
        for (int e = 0; e < 300; e++) begin
            int  len, gap, kind;
            bit [1:0] pat;
            kind = int'($urandom_range(0, 9));
            pat  = (kind < 4) ? 2'b01 : (kind < 8) ? 2'b10 : 2'b11;
            len  = int'($urandom_range(1, N + 4));
            gap  = int'($urandom_range(1, N + 6));
            if ($urandom_range(0, 39) == 0) begin
                reset = 1'b1;
                run_ticks(int'($urandom_range(1, 2)));
                reset = 1'b0;
            end
            set_sensors(pat);
            for (int t = 0; t < len; t++) begin
                bus.busy = ($urandom_range(0, 9) < 3);
                if ($urandom_range(0, 15) == 0) set_sensors(2'($urandom_range(1, 3)));
                tick();
            end
            set_sensors(2'b00);
            for (int t = 0; t < gap; t++) begin
                bus.busy = ($urandom_range(0, 9) < 3);
                tick();
            end
        end
        bus.busy = 1'b0;
        run_ticks(30);

`ifdef COIN_AUDIT_EN
        // Accepted counter saturates at 255 after 256 coins.
        reset = 1'b1;
        run_ticks(2);
        reset = 1'b0;
        run_ticks(N + 3);
        clear_seen();
        for (int c = 0; c < 256; c++) insert(2'b01, N + 2, N + 4);
        run_ticks(3);
        check("sat_pulses", n_coin_seen, 256);
        check("sat_accepted_cnt", int'(bus.accepted_cnt), 255);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/coin_acceptor.md
COIN_ACCEPTOR -- requirements
Module: coin_acceptor

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, default 4, stable-sample count (legal range 2..15) used for both insertion and release qualification.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 sense5_raw  input  1  asynchronous 5 Rs slot sensor level.
REQ-005 sense10_raw  input  1  asynchronous 10 Rs slot sensor level.
REQ-006 busy  input  1  downstream vending controller occupied (its dispense OR return5).
REQ-007 coin  output  2  registered code to vending controller: 00 none, 01 = 5 Rs, 10 = 10 Rs; 11 never driven.
REQ-008 reject  output  1  registered one-cycle pulse that opens the reject gate.
REQ-009 accepted_cnt  output  8  saturating count of coins emitted on coin; present only under COIN_AUDIT_EN.
REQ-010 rejected_cnt  output  8  saturating count of reject pulses; present only under COIN_AUDIT_EN.

Function
REQ-011 Each raw sensor SHALL pass through a two-flop synchronizer; all further logic uses only the synchronized pair {s10,s5}.
REQ-012 FSM states SHALL be IDLE, DEBOUNCE, WAIT_RELEASE.
REQ-013 IDLE: nonzero {s10,s5} -> DEBOUNCE, capture pattern, stability count = 1.
REQ-014 DEBOUNCE: same pattern -> count+1; different nonzero pattern -> recapture, count = 1; 00 -> IDLE with no output (glitch).
REQ-015 When count reaches DEBOUNCE_CYCLES, classify the captured pattern: 01 valid 5, 10 valid 10, 11 invalid; then -> WAIT_RELEASE.
REQ-016 Invalid classification SHALL produce reject = 1 for exactly one cycle and SHALL leave coin = 00.
REQ-017 Valid classification with busy = 0 and pending slot empty SHALL drive coin = code for exactly one cycle.
REQ-018 Valid classification with busy = 1 or pending slot occupied: store the code in the one-entry pending slot if empty; if the slot is full, reject for one cycle instead.
REQ-019 Pending slot SHALL be emitted as a one-cycle coin pulse in the first cycle busy = 0, then cleared.
REQ-020 On a cycle where the pending slot is emitted and a new valid classification occurs, the new code SHALL enter the freed slot.
REQ-021 Latency: raw stable high, first sampled at edge k, busy = 0 -> coin valid for the cycle after edge k+2+DEBOUNCE_CYCLES.
REQ-022 Consecutive coin pulses SHALL be separated by at least one cycle of coin = 00.
REQ-023 WAIT_RELEASE: -> IDLE after {s10,s5} = 00 for DEBOUNCE_CYCLES consecutive cycles; any nonzero sample restarts the count; no new coin is qualified meanwhile.
REQ-024 coin and reject SHALL never be asserted in the same cycle.

Reset
REQ-025 Reset SHALL clear the synchronizers, pending slot and counters, drive coin = 00 and reject = 0, and place the FSM in WAIT_RELEASE with release count 0.
REQ-026 As a result, a coin held in the slot across reset is never credited, and a debounce interrupted by reset emits nothing.

Configuration
REQ-027 Macro COIN_AUDIT_EN defined: accepted_cnt increments on each cycle coin != 00, and rejected_cnt increments on each reject pulse, both saturating at 255 and cleared by reset.
REQ-028 COIN_AUDIT_EN undefined: both counters and both ports are absent; all other behaviour is identical.

Verification
REQ-029 sense5_raw held high from edge 10, N = 4, busy = 0 -> coin = 01 for exactly one cycle after edge 16; reject stays 0.
REQ-030 sense10_raw 2-cycle glitch -> coin stays 00 and reject stays 0; FSM returns to IDLE.
REQ-031 Both sensors high together, stable -> reject pulse for one cycle; coin stays 00; rejected_cnt = 1 when the audit feature is compiled in.
REQ-032 busy = 1, insert 10 Rs, then insert 5 Rs -> first coin held in pending, second rejected; busy falls -> coin = 10 for one cycle.
REQ-033 Reset asserted mid-DEBOUNCE with sense5_raw held high -> no coin pulse until the sensor is low for N cycles and a fresh insertion is debounced.
REQ-034 256 valid coins with the audit feature compiled in -> accepted_cnt = 255 (saturated).
